// File: rtl/blur_frame_arbiter.sv
// Frame-granular arbiter sharing one blur core between two pixel streams.
// Grants the core to one stream for a full frame, then hides the source while the core pads.
module blur_frame_arbiter #(
    parameter int WIDTH  = 1280,
    parameter int HEIGHT = 720
) (
    input  logic       clock,
    input  logic       reset,
    output logic       in_rd_en0,
    output logic       in_rd_en1,
    input  logic       in_empty0,
    input  logic       in_empty1,
    input  logic [7:0] in_dout0,
    input  logic [7:0] in_dout1,
    input  logic       core_in_rd_en,
    output logic       core_in_empty,
    output logic [7:0] core_in_dout,
    input  logic       core_out_wr_en,
    output logic       core_out_full,
    input  logic [7:0] core_out_din,
    output logic       out_wr_en0,
    output logic       out_wr_en1,
    input  logic       out_full0,
    input  logic       out_full1,
    output logic [7:0] out_din0,
    output logic [7:0] out_din1,
    output logic       active_src,
    output logic       busy,
    output logic       frame_done
);

    localparam int PIXEL_COUNT = WIDTH * HEIGHT;
    localparam int CW = $clog2(PIXEL_COUNT);
    localparam logic [CW-1:0] LAST = CW'(PIXEL_COUNT - 1);

    typedef enum logic [1:0] {IDLE, FEED, DRAIN} state_t;

    state_t        state;
    logic          sel;
    logic          prio;
    logic [CW-1:0] in_cnt;
    logic [CW-1:0] out_cnt;

    logic       feeding, granted;
    logic       sel_empty, sel_full;
    logic [7:0] sel_dout;
    logic       rd_acc, wr_acc;

    assign feeding   = (state == FEED);
    assign granted   = (state != IDLE);
    assign sel_empty = sel ? in_empty1 : in_empty0;
    assign sel_full  = sel ? out_full1 : out_full0;
    assign sel_dout  = sel ? in_dout1 : in_dout0;

    assign rd_acc = feeding & core_in_rd_en & ~sel_empty;
    assign wr_acc = granted & core_out_wr_en & ~sel_full;

    // DRAIN looks exactly like an empty source, so the core pads with zeros.
    assign core_in_empty = feeding ? sel_empty : 1'b1;
    assign core_in_dout  = feeding ? sel_dout : '0;
    assign core_out_full = granted ? sel_full : 1'b1;

    assign in_rd_en0  = rd_acc & ~sel;
    assign in_rd_en1  = rd_acc & sel;
    assign out_wr_en0 = wr_acc & ~sel;
    assign out_wr_en1 = wr_acc & sel;
    assign out_din0   = (granted & ~sel) ? core_out_din : '0;
    assign out_din1   = (granted & sel) ? core_out_din : '0;

    assign active_src = sel;
    assign busy       = granted;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            sel        <= 1'b0;
            prio       <= 1'b0;
            in_cnt     <= '0;
            out_cnt    <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (~in_empty0 | ~in_empty1) begin
                        state   <= FEED;
                        sel     <= (~in_empty0 & ~in_empty1) ? prio : in_empty0;
                        in_cnt  <= '0;
                        out_cnt <= '0;
                    end
                end
                FEED, DRAIN: begin
                    if (rd_acc) begin
                        in_cnt <= in_cnt + CW'(1);
                        if (in_cnt == LAST) state <= DRAIN;
                    end
                    // Completion is assigned last so it overrides the move to DRAIN.
                    if (wr_acc) begin
                        out_cnt <= out_cnt + CW'(1);
                        if (out_cnt == LAST) begin
                            state      <= IDLE;
                            prio       <= ~sel;
                            frame_done <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
